// File: rtl/tx_slot_scheduler_if.sv
// tx_slot_scheduler_if
// Groups the scheduler's burst-feeder signals and its upstream payload
// handshake into one bundle.
//
// Signals:
//   payload_bit    payload data from the upstream source
//   payload_valid  upstream has a payload bit on payload_bit
//   payload_ready  scheduler accepts payload_bit this cycle
//   is_armed       burst feeder is ready to accept a fire
//   fire_burst     one-cycle pulse starting a burst
//   tx_symbol      symbol value presented to the modulator
//   pa_enable      RF power amplifier enable
//
// Handshake: a payload bit transfers on every rising clock edge where
// payload_valid && payload_ready are both high. payload_valid must not depend
// on payload_ready. payload_ready may drop without a transfer; the source may
// change payload_bit or drop payload_valid in any cycle without a transfer.
//
// Modports: slave is the scheduler side, master is the source/feeder side.
interface tx_slot_scheduler_if;
  logic payload_bit;
  logic payload_valid;
  logic payload_ready;
  logic is_armed;
  logic fire_burst;
  logic tx_symbol;
  logic pa_enable;

  modport master (
    output payload_bit, payload_valid, is_armed,
    input  payload_ready, fire_burst, tx_symbol, pa_enable
  );

  modport slave (
    input  payload_bit, payload_valid, is_armed,
    output payload_ready, fire_burst, tx_symbol, pa_enable
  );
endinterface

// File: rtl/tx_slot_scheduler.sv
// tx_slot_scheduler
// TDMA burst scheduler for the GMSK transmit path. Symbol-position, slot and
// frame counters advance on symbol_tick. At a slot boundary into an enabled
// slot it fires one burst: head tail bits (0), payload from the upstream
// source through a one-entry buffer, end tail bits (0), then guard (1, PA off).
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-low
//   enable       scheduler enable, sampled only on boundary ticks
//   slot_mask    per-slot burst enable, bit n sampled on the boundary into slot n
//   symbol_tick  one-cycle pulse per symbol period
//   bus          feeder / payload bundle (slave side)
//   slot_index   current slot
//   sym_pos      current symbol position within the slot
//   frame_count  frame counter, wraps 65535 -> 0
//   burst_active high from fire through the last end tail symbol
//   underrun     pulse: a payload symbol was due with no data available
//   missed_slot  pulse: an enabled slot was skipped because is_armed was low
//   state_dbg    current FSM state encoding
module tx_slot_scheduler #(
  parameter int SLOT_SYMBOLS    = 156,
  parameter int NUM_SLOTS       = 8,
  parameter int TAIL_SYMBOLS    = 3,
  parameter int PAYLOAD_SYMBOLS = 142,
  parameter int GUARD_SYMBOLS   = 8,
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int POS_W  = $clog2(SLOT_SYMBOLS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_SLOTS-1:0] slot_mask,
  input  logic                 symbol_tick,
  tx_slot_scheduler_if.slave   bus,
  output logic [SLOT_W-1:0]    slot_index,
  output logic [POS_W-1:0]     sym_pos,
  output logic [15:0]          frame_count,
  output logic                 burst_active,
  output logic                 underrun,
  output logic                 missed_slot,
  output logic [2:0]           state_dbg
);

  localparam int ACC_W = $clog2(PAYLOAD_SYMBOLS + 1);

  // Region boundaries, expressed as the sym_pos value that opens each region.
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(SLOT_SYMBOLS - 1);
  localparam logic [POS_W-1:0]  POS_PAY   = POS_W'(TAIL_SYMBOLS);
  localparam logic [POS_W-1:0]  POS_TAIL  = POS_W'(TAIL_SYMBOLS + PAYLOAD_SYMBOLS);
  localparam logic [POS_W-1:0]  POS_GUARD = POS_W'(2 * TAIL_SYMBOLS + PAYLOAD_SYMBOLS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [ACC_W-1:0]  ACC_FULL  = ACC_W'(PAYLOAD_SYMBOLS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEAD    = 3'd1,
    S_PAYLOAD = 3'd2,
    S_TAILEND = 3'd3,
    S_GUARD   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               tx_q, tx_d;
  logic               pa_q, pa_d;
  logic               fire_q, fire_d;
  logic               active_d, under_d, missed_d;
  logic [POS_W-1:0]   pos_d;
  logic [SLOT_W-1:0]  slot_d;
  logic [15:0]        frame_d;

  // One-entry payload buffer and count of payload symbols accounted for in
  // the current burst (transfers plus underrun skips).
  logic               buf_full, buf_full_d;
  logic               buf_bit, buf_bit_d;
  logic [ACC_W-1:0]   accepted, acc_d;

  logic               ready;
  logic               transfer;
  logic               at_last;
  logic [SLOT_W-1:0]  next_slot;
  logic [POS_W-1:0]   pos_inc;
  logic               pay_step;

  assign ready     = burst_active && !buf_full && (accepted < ACC_FULL);
  assign transfer  = bus.payload_valid && ready;
  assign at_last   = (sym_pos == POS_LAST);
  assign next_slot = (slot_index == SLOT_LAST) ? '0 : slot_index + SLOT_W'(1);
  assign pos_inc   = at_last ? '0 : sym_pos + POS_W'(1);

  assign bus.payload_ready = ready;
  assign bus.fire_burst    = fire_q;
  assign bus.tx_symbol     = tx_q;
  assign bus.pa_enable     = pa_q;
  assign state_dbg         = state_q;

  always_comb begin
    state_d    = state_q;
    pos_d      = sym_pos;
    slot_d     = slot_index;
    frame_d    = frame_count;
    tx_d       = tx_q;
    pa_d       = pa_q;
    active_d   = burst_active;
    fire_d     = 1'b0;
    under_d    = 1'b0;
    missed_d   = 1'b0;
    buf_full_d = buf_full;
    buf_bit_d  = buf_bit;
    acc_d      = accepted;
    pay_step   = 1'b0;

    if (transfer) begin
      buf_full_d = 1'b1;
      buf_bit_d  = bus.payload_bit;
      acc_d      = accepted + ACC_W'(1);
    end

    if (symbol_tick) begin
      pos_d = pos_inc;
      if (at_last) begin
        slot_d = next_slot;
        if (slot_index == SLOT_LAST) begin
          frame_d = frame_count + 16'd1;
        end
      end

      case (state_q)
        // Burst decisions are only taken from IDLE or GUARD, so a running
        // burst ignores enable/slot_mask changes until its guard.
        S_IDLE, S_GUARD: begin
          if (at_last) begin
            if (enable && slot_mask[next_slot] && bus.is_armed) begin
              state_d    = S_HEAD;
              fire_d     = 1'b1;
              active_d   = 1'b1;
              pa_d       = 1'b1;
              tx_d       = 1'b0;
              acc_d      = '0;
              buf_full_d = 1'b0;
            end else begin
              state_d  = S_IDLE;
              tx_d     = 1'b1;
              pa_d     = 1'b0;
              active_d = 1'b0;
              missed_d = enable && slot_mask[next_slot];
            end
          end
        end
        S_HEAD: begin
          if (pos_d == POS_PAY) begin
            state_d  = S_PAYLOAD;
            pay_step = 1'b1;
          end
        end
        S_PAYLOAD: begin
          if (pos_d == POS_TAIL) begin
            state_d = S_TAILEND;
            tx_d    = 1'b0;
          end else begin
            pay_step = 1'b1;
          end
        end
        S_TAILEND: begin
          if (pos_d == POS_GUARD) begin
            state_d  = S_GUARD;
            tx_d     = 1'b1;
            pa_d     = 1'b0;
            active_d = 1'b0;
          end
        end
        default: begin
          state_d  = S_IDLE;
          tx_d     = 1'b1;
          pa_d     = 1'b0;
          active_d = 1'b0;
        end
      endcase
    end

    // Emit one payload symbol: buffered bit first, else a bit arriving in
    // this very cycle passes straight through, else substitute 1 and flag
    // the underrun. A skipped symbol still counts so the burst length holds.
    if (pay_step) begin
      if (buf_full) begin
        tx_d       = buf_bit;
        buf_full_d = 1'b0;
      end else if (transfer) begin
        tx_d       = bus.payload_bit;
        buf_full_d = 1'b0;
      end else begin
        tx_d    = 1'b1;
        under_d = 1'b1;
        acc_d   = accepted + ACC_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sym_pos      <= '0;
      slot_index   <= '0;
      frame_count  <= '0;
      tx_q         <= 1'b1;
      pa_q         <= 1'b0;
      fire_q       <= 1'b0;
      burst_active <= 1'b0;
      underrun     <= 1'b0;
      missed_slot  <= 1'b0;
      buf_full     <= 1'b0;
      buf_bit      <= 1'b0;
      accepted     <= '0;
    end else begin
      state_q      <= state_d;
      sym_pos      <= pos_d;
      slot_index   <= slot_d;
      frame_count  <= frame_d;
      tx_q         <= tx_d;
      pa_q         <= pa_d;
      fire_q       <= fire_d;
      burst_active <= active_d;
      underrun     <= under_d;
      missed_slot  <= missed_d;
      buf_full     <= buf_full_d;
      buf_bit      <= buf_bit_d;
      accepted     <= acc_d;
    end
  end

endmodule

// File: tb/tb_tx_slot_scheduler.sv
// tb_tx_slot_scheduler
// Directed bench for tx_slot_scheduler with 16-symbol slots (tail 2,
// payload 10, guard 2) and 4 slots per frame. The driver pushes the expected
// post-tick outputs into exp_q; the monitor pops one entry in each cycle that
// follows a symbol_tick and compares.
module tb_tx_slot_scheduler;

  localparam int W = 28;
  // {fire, missed, underrun, burst_active, pa_enable, tx_symbol, slot, pos, frame}
  localparam logic [63:0] RESET_SNAP = {32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                        1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 16'd0};

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] slot_mask;
  logic       symbol_tick;
  logic [1:0] slot_index;
  logic [3:0] sym_pos;
  logic [15:0] frame_count;
  logic       burst_active;
  logic       underrun;
  logic       missed_slot;
  logic [2:0] state_dbg;

  tx_slot_scheduler_if bus ();

  tx_slot_scheduler #(
    .SLOT_SYMBOLS   (16),
    .NUM_SLOTS      (4),
    .TAIL_SYMBOLS   (2),
    .PAYLOAD_SYMBOLS(10),
    .GUARD_SYMBOLS  (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .slot_mask   (slot_mask),
    .symbol_tick (symbol_tick),
    .bus         (bus),
    .slot_index  (slot_index),
    .sym_pos     (sym_pos),
    .frame_count (frame_count),
    .burst_active(burst_active),
    .underrun    (underrun),
    .missed_slot (missed_slot),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- bench state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fire = 0, n_missed = 0, n_under = 0, n_xfer = 0;

  logic [3:0]  m_pos;
  logic [1:0]  m_slot;
  logic [15:0] m_frame;
  logic [3:0]  burst_slot;
  logic [3:0]  miss_slot;
  logic [0:9]  pat;
  logic [0:9]  drop;
  logic        src_en;
  int          gap;
  int          pay_idx;
  logic        tick_seen = 1'b0;

  // ---------------- helpers ----------------
  function automatic logic [63:0] snap();
    return {32'd0, bus.fire_burst, bus.tx_symbol, bus.pa_enable, bus.payload_ready,
            burst_active, underrun, missed_slot, state_dbg, slot_index, sym_pos,
            frame_count};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h", name, act, exp);
  endtask

  task automatic update_src();
    if (pay_idx < 10) begin
      bus.payload_bit   = pat[pay_idx];
      bus.payload_valid = src_en && !drop[pay_idx];
    end else begin
      bus.payload_bit   = 1'b0;
      bus.payload_valid = src_en;
    end
  endtask

  task automatic clear_model();
    m_pos = 4'd0; m_slot = 2'd0; m_frame = 16'd0; pay_idx = 0;
    burst_slot = 4'd0; miss_slot = 4'd0;
    update_src();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    symbol_tick = 1'b0;
    clear_model();
    repeat (3) @(negedge clock);
    check("reset_hold", snap(), RESET_SNAP);
    reset = 1'b1;
  endtask

  // Push the expected post-tick outputs, then issue one symbol_tick.
  task automatic step();
    logic [3:0]  np;
    logic [1:0]  ns;
    logic [15:0] nf;
    logic in_b, pay, e_tx, e_pa, e_fire, e_miss, e_und;
    int k;
    np = (m_pos == 4'd15) ? 4'd0 : m_pos + 4'd1;
    ns = m_slot;
    nf = m_frame;
    if (m_pos == 4'd15) begin
      ns = m_slot + 2'd1;
      if (m_slot == 2'd3) nf = m_frame + 16'd1;
    end
    in_b = burst_slot[ns];
    pay  = (np >= 4'd2) && (np <= 4'd11);
    k    = int'(np) - 2;
    if (!in_b)    e_tx = 1'b1;
    else if (pay) e_tx = drop[k] ? 1'b1 : pat[k];
    else          e_tx = (np >= 4'd14);
    e_pa   = in_b && (np < 4'd14);
    e_fire = in_b && (np == 4'd0);
    e_miss = miss_slot[ns] && (np == 4'd0);
    e_und  = 1'b0;
    if (in_b && pay) e_und = drop[k];
    exp_q.push_back({e_fire, e_miss, e_und, e_pa, e_pa, e_tx, ns, np, nf});
    m_pos = np; m_slot = ns; m_frame = nf;
    symbol_tick = 1'b1;
    @(negedge clock);
    symbol_tick = 1'b0;
    if (np == 4'd0) pay_idx = 0;
    else if (in_b && pay) pay_idx++;
    update_src();
    repeat (gap) @(negedge clock);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
    wait_drain();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clock) tick_seen <= symbol_tick;

  always @(negedge clock) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    if (tick_seen) begin
      act = {bus.fire_burst, missed_slot, underrun, burst_active, bus.pa_enable,
             bus.tx_symbol, slot_index, sym_pos, frame_count};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_output act=%h", act);
      end else begin
        exp = exp_q.pop_front();
        if (act === exp) n_pass++;
        else $display("FAIL tick_out slot=%0d pos=%0d act=%h exp=%h (fire,miss,und,active,pa,tx,slot,pos,frame)",
                      exp[21:20], exp[19:16], act, exp);
      end
    end
  end

  // Event counters, sampled mid-cycle well away from both clock edges.
  always @(negedge clock) begin
    #3;
    if (bus.fire_burst) n_fire++;
    if (missed_slot) n_missed++;
    if (underrun) n_under++;
    if (bus.payload_valid && bus.payload_ready) n_xfer++;
  end

  // ---------------- stimulus ----------------
  initial begin
    int f0, m0, u0, x0;
    reset = 1'b0; enable = 1'b0; slot_mask = 4'd0; symbol_tick = 1'b0;
    bus.is_armed = 1'b0; pat = 10'd0; drop = 10'd0; src_en = 1'b0; gap = 1;
    do_reset();

    // Counting: 64 ticks with scheduler disabled.
    enable = 1'b0; slot_mask = 4'b1111; gap = 1;
    f0 = n_fire;
    run(64);
    check("count_frame", 64'(frame_count), 64'd1);
    check("count_no_fire", 64'(n_fire - f0), 64'd0);

    // Single burst into slot 1; enable dropped mid-burst.
    do_reset();
    enable = 1'b1; slot_mask = 4'b0010; bus.is_armed = 1'b1;
    pat = 10'b1010101010; drop = 10'b0000000000; src_en = 1'b1; gap = 2;
    burst_slot = 4'b0010; update_src();
    f0 = n_fire; m0 = n_missed; u0 = n_under; x0 = n_xfer;
    for (int i = 0; i < 20; i++) step();
    enable = 1'b0;
    run(28);
    check("single_fire", 64'(n_fire - f0), 64'd1);
    check("single_xfer", 64'(n_xfer - x0), 64'd10);
    check("single_underrun", 64'(n_under - u0), 64'd0);
    check("single_missed", 64'(n_missed - m0), 64'd0);

    // Not armed at the boundary into slot 2.
    do_reset();
    enable = 1'b1; slot_mask = 4'b0100; bus.is_armed = 1'b0; gap = 1;
    miss_slot = 4'b0100;
    f0 = n_fire; m0 = n_missed;
    run(40);
    check("noarm_missed", 64'(n_missed - m0), 64'd1);
    check("noarm_fire", 64'(n_fire - f0), 64'd0);

    // Underrun on payload symbols 4 and 5.
    do_reset();
    enable = 1'b1; slot_mask = 4'b0010; bus.is_armed = 1'b1;
    pat = 10'b0011001100; drop = 10'b0000110000; src_en = 1'b1; gap = 2;
    burst_slot = 4'b0010; update_src();
    f0 = n_fire; u0 = n_under; x0 = n_xfer;
    run(32);
    check("under_count", 64'(n_under - u0), 64'd2);
    check("under_xfer", 64'(n_xfer - x0), 64'd8);
    check("under_fire", 64'(n_fire - f0), 64'd1);

    // Adjacent slots 1 and 2, ticks every cycle.
    do_reset();
    enable = 1'b1; slot_mask = 4'b0110; bus.is_armed = 1'b1;
    pat = 10'b1110001101; drop = 10'b0000000000; src_en = 1'b1; gap = 0;
    burst_slot = 4'b0110; update_src();
    f0 = n_fire; u0 = n_under; x0 = n_xfer;
    run(48);
    check("adj_fire", 64'(n_fire - f0), 64'd2);
    check("adj_xfer", 64'(n_xfer - x0), 64'd20);
    check("adj_underrun", 64'(n_under - u0), 64'd0);

    // Reset while in PAYLOAD at position 7.
    do_reset();
    enable = 1'b1; slot_mask = 4'b0010; bus.is_armed = 1'b1;
    pat = 10'b1010101010; drop = 10'b0000000000; src_en = 1'b1; gap = 1;
    burst_slot = 4'b0010; update_src();
    run(23);
    check("mid_pos_before_reset", 64'(sym_pos), 64'd7);
    reset = 1'b0;
    @(negedge clock);
    check("reset_mid_payload", snap(), RESET_SNAP);
    reset = 1'b1;
    enable = 1'b0;
    clear_model();
    run(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tx_slot_scheduler.md
Name: tx_slot_scheduler

Overview:
TDMA burst scheduler for the GMSK transmit path. It keeps symbol-position, timeslot and frame counters, driven by the modulator's symbol_tick. At each slot boundary where the slot is enabled, it fires one burst into the burst feeder/modulator. Each burst is sequenced as head tail bits, payload from an upstream valid/ready source, end tail bits, then a guard period. It also drives PA enable and reports underruns and missed slots.

Parameters:
SLOT_SYMBOLS, 156, symbols per timeslot; must equal 2*TAIL_SYMBOLS + PAYLOAD_SYMBOLS + GUARD_SYMBOLS.
NUM_SLOTS, 8, timeslots per frame.
TAIL_SYMBOLS, 3, tail symbols (value 0) at each end of a burst.
PAYLOAD_SYMBOLS, 142, payload symbols per burst.
GUARD_SYMBOLS, 8, guard symbols with PA off (value 1).

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-low.
enable  in  1  scheduler enable; sampled only at slot boundaries.
slot_mask  in  NUM_SLOTS  bit i enables bursts in slot i; sampled at the boundary into slot i.
symbol_tick  in  1  one-cycle pulse per symbol period from the modulator.
is_armed  in  1  burst feeder ready to accept fire.
fire_burst  out  1  one-cycle pulse starting a burst.
tx_symbol  out  1  symbol value presented to the modulator.
pa_enable  out  1  RF PA enable.
payload_bit  in  1  upstream payload data.
payload_valid  in  1  upstream data valid.
payload_ready  out  1  scheduler accepts payload_bit this cycle.
slot_index  out  $clog2(NUM_SLOTS)  current slot.
sym_pos  out  $clog2(SLOT_SYMBOLS)  current symbol position in slot.
frame_count  out  16  frame counter; wraps at 65535 -> 0.
burst_active  out  1  high from fire through the last end tail symbol.
underrun  out  1  one-cycle pulse when a payload symbol was due but the buffer was empty.
missed_slot  out  1  one-cycle pulse when an enabled slot was skipped because is_armed was low.

Behaviour:
- Reset (reset==0 at a clock edge) forces every output to its reset value, state to IDLE and the payload buffer to empty. This holds from any state, including mid-burst.
- Output reset values: fire_burst=0, tx_symbol=1, pa_enable=0, payload_ready=0, slot_index=0, sym_pos=0, frame_count=0, burst_active=0, underrun=0, missed_slot=0.
- Counters advance only on symbol_tick:
  - sym_pos increments, wrapping from SLOT_SYMBOLS-1 to 0.
  - On that wrap, slot_index increments mod NUM_SLOTS.
  - On the slot wrap from NUM_SLOTS-1 to 0, frame_count increments.
- Boundary tick: a symbol_tick with sym_pos==SLOT_SYMBOLS-1, where next slot n = (slot_index+1) mod NUM_SLOTS. Evaluated only in IDLE or GUARD:
  - If enable && slot_mask[n] && is_armed: fire_burst pulses in the following cycle; state goes to HEAD; the payload accept counter clears.
  - If enable && slot_mask[n] && !is_armed: missed_slot pulses in the following cycle; state stays IDLE.
  - Otherwise: state goes to IDLE.
- States, keyed on the new sym_pos after each tick:
  - HEAD (positions 0..T-1): tx_symbol=0, pa_enable=1.
  - PAYLOAD (positions T..T+P-1): tx_symbol comes from the buffer.
  - TAILEND (positions T+P..2T+P-1): tx_symbol=0, pa_enable=1.
  - GUARD (remaining positions): tx_symbol=1, pa_enable=0, burst_active=0.
  - IDLE: tx_symbol=1, pa_enable=0.
- Transitions occur on the tick that moves sym_pos into the next region. tx_symbol, pa_enable and state register on the same edge as the sym_pos update, so latency is 1 cycle from symbol_tick.
- burst_active and pa_enable rise with fire_burst and fall on the tick that enters GUARD.
- Payload buffer: one entry.
  - payload_ready = burst_active && !buf_full && accepted < PAYLOAD_SYMBOLS. Prefetching therefore starts in the cycle of fire.
  - A transfer occurs when valid && ready: buffer is filled and accepted increments.
  - On a tick that enters or stays in PAYLOAD: if buf_full, tx_symbol takes the buffer value and the buffer empties. If a transfer and the tick coincide with the buffer empty, the incoming bit is consumed directly.
  - If the buffer is empty and no transfer coincides with the tick: tx_symbol=1 and underrun pulses. The skipped bit still counts toward PAYLOAD_SYMBOLS, so accepted increments and the burst length is unchanged.
- enable or slot_mask changes mid-burst do not affect the current burst.
- A burst ends cleanly through TAILEND and GUARD.
- Back-to-back bursts in adjacent enabled slots are allowed: GUARD goes directly to HEAD.

Test Plan:
All scenarios use SLOT_SYMBOLS=16, TAIL=2, PAYLOAD=10, GUARD=2, NUM_SLOTS=4.
- Counting: hold reset low 3 cycles, release, give 64 ticks with enable=0 -> sym_pos wraps every 16 ticks, slot_index goes 0,1,2,3,0, frame_count=1, fire_burst never pulses.
- Single burst: slot_mask=4'b0010, is_armed=1, valid always high with payload 1010101010 -> one fire_burst at the slot-0->1 boundary; tx_symbol sequence 0,0,1,0,1,0,1,0,1,0,1,0,0,0,1,1; pa_enable high for exactly 14 symbols; 10 transfers; no underrun.
- Not armed: slot_mask=4'b0100, is_armed=0 at the boundary -> missed_slot pulse once, no fire, pa_enable stays 0.
- Underrun: valid dropped for payload symbols 4 and 5 -> two underrun pulses, tx_symbol=1 at those positions, TAILEND still starts at position 12.
- Adjacent slots: slot_mask=4'b0110 -> two fire_burst pulses 16 ticks apart; pa_enable low for exactly the 2 guard symbols between them.
- Reset mid-PAYLOAD: assert reset at position 7 -> next cycle pa_enable=0, tx_symbol=1, payload_ready=0, counters 0, state IDLE.
